// File: rtl/dphy_rx_pkt_pkg.sv
// Shared types, constants and the byte-wise CRC-16 step for the D-PHY packet layer.
package dphy_rx_pkt_pkg;

  typedef enum logic [2:0] {StIdle, StHdr, StPayload, StCrc, StTrail} state_e;

  localparam logic [15:0] CRC16_POLY_REFL = 16'h8408;
  localparam int unsigned HDR_BYTES       = 4;
  localparam int unsigned FOOTER_BYTES    = 2;

  // Reflected CRC-16 (x^16+x^12+x^5+1), one byte taken LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC16_POLY_REFL;
      else                c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/dphy_rx_pkt_parser_if.sv
// Aligned HS byte stream from the D-PHY receiver to the packet parser.
interface dphy_rx_pkt_parser_if;
  logic [7:0] RxDataHS;
  logic       RxValidHS;
  logic       RxActiveHS;
  logic       RxSyncHS;

  modport master (output RxDataHS, RxValidHS, RxActiveHS, RxSyncHS);
  modport slave  (input  RxDataHS, RxValidHS, RxActiveHS, RxSyncHS);
endinterface

// File: rtl/dphy_crc16_byte.sv
// Registered CRC-16 accumulator, one byte per enabled cycle; init has priority over en.
module dphy_crc16_byte
  import dphy_rx_pkt_pkg::*;
#(
  parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_d, crc_q;

  always_comb begin
    crc_d = crc_q;
    if (init_i)    crc_d = CRC_INIT;
    else if (en_i) crc_d = crc16_byte(crc_q, data_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) crc_q <= CRC_INIT;
    else       crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/dphy_rx_pkt_parser.sv
// Splits the HS byte stream into header, payload and footer; checks CRC and flags aborts.
module dphy_rx_pkt_parser
  import dphy_rx_pkt_pkg::*;
#(
  parameter logic [5:0]  SHORT_DT_MAX = 6'h0F,
  parameter logic [15:0] CRC_INIT     = 16'hFFFF,
  parameter bit          CRC_EN       = 1'b1
) (
  input  logic                       RxByteClkHS,
  input  logic                       RxRst,
  dphy_rx_pkt_parser_if.slave        rx_if,
  output logic                       PktHdrValid,
  output logic [7:0]                 PktDI,
  output logic [15:0]                PktWC,
  output logic [7:0]                 PktECC,
  output logic [7:0]                 PayloadData,
  output logic                       PayloadValid,
  output logic                       PayloadLast,
  output logic                       PktDone,
  output logic                       CrcErr,
  output logic                       PktAbort
);

  state_e      state_d, state_q;
  logic [1:0]  idx_d, idx_q;
  logic [15:0] cnt_d, cnt_q;
  logic [7:0]  foot_lo_d, foot_lo_q;
  logic [7:0]  di_d, di_q, ecc_d, ecc_q, pd_d, pd_q;
  logic [15:0] wc_d, wc_q;
  logic        hv_d, hv_q, pv_d, pv_q, pl_d, pl_q;
  logic        done_d, done_q, err_d, err_q, abort_d, abort_q;
  logic        crc_init, crc_en;
  logic [15:0] crc;

  logic       valid, active, sync;
  logic [7:0] data;
  assign valid  = rx_if.RxValidHS;
  assign active = rx_if.RxActiveHS;
  assign sync   = rx_if.RxSyncHS;
  assign data   = rx_if.RxDataHS;

  dphy_crc16_byte #(.CRC_INIT(CRC_INIT)) u_crc (
    .clk_i  (RxByteClkHS),
    .rst_i  (RxRst),
    .init_i (crc_init),
    .en_i   (crc_en),
    .data_i (data),
    .crc_o  (crc)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    foot_lo_d = foot_lo_q;
    di_d      = di_q;
    wc_d      = wc_q;
    ecc_d     = ecc_q;
    pd_d      = pd_q;
    hv_d      = 1'b0;
    pv_d      = 1'b0;
    pl_d      = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    abort_d   = 1'b0;
    crc_init  = 1'b0;
    crc_en    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (sync && active) begin
          state_d = StHdr;
          idx_d   = 2'd0;
        end
      end
      StHdr: begin
        if (valid) begin
          idx_d = idx_q + 2'd1;
          unique case (idx_q)
            2'd0:    di_d = data;
            2'd1:    wc_d[7:0] = data;
            2'd2:    wc_d[15:8] = data;
            default: begin
              ecc_d = data;
              hv_d  = 1'b1;
              idx_d = 2'd0;
              if (di_q[5:0] <= SHORT_DT_MAX) begin
                done_d  = 1'b1;
                state_d = StTrail;
              end else begin
                crc_init = 1'b1;
                cnt_d    = wc_q;
                state_d  = (wc_q == 16'd0) ? StCrc : StPayload;
              end
            end
          endcase
        end
      end
      StPayload: begin
        if (valid) begin
          pv_d   = 1'b1;
          pd_d   = data;
          crc_en = 1'b1;
          cnt_d  = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            pl_d    = 1'b1;
            idx_d   = 2'd0;
            state_d = StCrc;
          end
        end
      end
      StCrc: begin
        if (valid) begin
          if (idx_q == 2'd0) begin
            foot_lo_d = data;
            idx_d     = 2'd1;
          end else begin
            done_d  = 1'b1;
            err_d   = CRC_EN && ({data, foot_lo_q} != crc);
            idx_d   = 2'd0;
            state_d = StTrail;
          end
        end
      end
      StTrail: begin
        if (sync && active) begin
          state_d = StHdr;
          idx_d   = 2'd0;
        end else if (!active) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides whatever the byte on this cycle would have produced.
    if ((state_q == StHdr || state_q == StPayload || state_q == StCrc) && (!active || sync)) begin
      abort_d  = 1'b1;
      state_d  = active ? StHdr : StIdle;
      idx_d    = 2'd0;
      cnt_d    = cnt_q;
      hv_d     = 1'b0;
      pv_d     = 1'b0;
      pl_d     = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;
      crc_init = 1'b0;
      crc_en   = 1'b0;
      pd_d     = pd_q;
      di_d     = di_q;
      wc_d     = wc_q;
      ecc_d    = ecc_q;
    end
  end

  always_ff @(posedge RxByteClkHS) begin
    if (RxRst) begin
      state_q   <= StIdle;
      idx_q     <= 2'd0;
      cnt_q     <= 16'd0;
      foot_lo_q <= 8'd0;
      di_q      <= 8'd0;
      wc_q      <= 16'd0;
      ecc_q     <= 8'd0;
      pd_q      <= 8'd0;
      hv_q      <= 1'b0;
      pv_q      <= 1'b0;
      pl_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      foot_lo_q <= foot_lo_d;
      di_q      <= di_d;
      wc_q      <= wc_d;
      ecc_q     <= ecc_d;
      pd_q      <= pd_d;
      hv_q      <= hv_d;
      pv_q      <= pv_d;
      pl_q      <= pl_d;
      done_q    <= done_d;
      err_q     <= err_d;
      abort_q   <= abort_d;
    end
  end

  assign PktHdrValid  = hv_q;
  assign PktDI        = di_q;
  assign PktWC        = wc_q;
  assign PktECC       = ecc_q;
  assign PayloadData  = pd_q;
  assign PayloadValid = pv_q;
  assign PayloadLast  = pl_q;
  assign PktDone      = done_q;
  assign CrcErr       = err_q;
  assign PktAbort     = abort_q;

endmodule
